// File: rtl/logic_gates.sv
// Registered bank of the seven basic two-input logic functions, applied bitwise.
// One lane per bit; all seven results are captured together with a single valid.

module logic_gates_lane (
  input  logic       i_a,
  input  logic       i_b,
  output logic [6:0] o_y
);
  // Bit order matches y1..y7 in the top: [0]=AND ... [6]=NOT a
  assign o_y[0] = i_a & i_b;
  assign o_y[1] = i_a | i_b;
  assign o_y[2] = ~(i_a & i_b);
  assign o_y[3] = ~(i_a | i_b);
  assign o_y[4] = i_a ^ i_b;
  assign o_y[5] = ~(i_a ^ i_b);
  assign o_y[6] = ~i_a;
endmodule

module logic_gates #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y2,
  output logic [WIDTH-1:0] y3,
  output logic [WIDTH-1:0] y4,
  output logic [WIDTH-1:0] y5,
  output logic [WIDTH-1:0] y6,
  output logic [WIDTH-1:0] y7
);
  localparam int NFN = 7;

  logic [WIDTH-1:0][NFN-1:0] w_lane;
  logic [NFN-1:0][WIDTH-1:0] w_fn;
  logic [NFN-1:0][WIDTH-1:0] r_y;
  logic                      r_out_valid;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_lane
      logic_gates_lane u_lane (
        .i_a (a[gi]),
        .i_b (b[gi]),
        .o_y (w_lane[gi])
      );
    end
  endgenerate

  // Regroup lane-major results into function-major words
  always_comb begin
    w_fn = '0;
    for (int k = 0; k < NFN; k++)
      for (int i = 0; i < WIDTH; i++)
        w_fn[k][i] = w_lane[i][k];
  end

  // Single register bank so no output can update without the others;
  // inverting outputs read 0 during reset, not the a=b=0 result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_y         <= '0;
      r_out_valid <= 1'b0;
    end else if (in_valid) begin
      r_y         <= w_fn;
      r_out_valid <= 1'b1;
    end
  end

  assign out_valid = r_out_valid;
  assign y1 = r_y[0];
  assign y2 = r_y[1];
  assign y3 = r_y[2];
  assign y4 = r_y[3];
  assign y5 = r_y[4];
  assign y6 = r_y[5];
  assign y7 = r_y[6];
endmodule

// File: tb/tb_logic_gates.sv
// Directed and random checks of logic_gates at WIDTH=1 and WIDTH=8.
module tb_logic_gates;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       iv1, ov1;
  logic [0:0] a1, b1, y1_1, y2_1, y3_1, y4_1, y5_1, y6_1, y7_1;
  logic       iv8, ov8;
  logic [7:0] a8, b8, y1_8, y2_8, y3_8, y4_8, y5_8, y6_8, y7_8;

  logic [6:0]  w_o1;
  logic [55:0] w_o8;
  assign w_o1 = {y1_1, y2_1, y3_1, y4_1, y5_1, y6_1, y7_1};
  assign w_o8 = {y1_8, y2_8, y3_8, y4_8, y5_8, y6_8, y7_8};

  logic_gates #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .a(a1), .b(b1), .out_valid(ov1),
    .y1(y1_1), .y2(y2_1), .y3(y3_1), .y4(y4_1), .y5(y5_1), .y6(y6_1), .y7(y7_1)
  );

  logic_gates #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .a(a8), .b(b8), .out_valid(ov8),
    .y1(y1_8), .y2(y2_8), .y3(y3_8), .y4(y4_8), .y5(y5_8), .y6(y6_8), .y7(y7_8)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Reference for the random stream: {AND,OR,NAND,NOR,XOR,XNOR,NOT a}
  function automatic logic [55:0] ref8(input logic [7:0] a, input logic [7:0] b);
    return {a & b, a | b, ~(a & b), ~(a | b), a ^ b, ~(a ^ b), ~a};
  endfunction

  // WIDTH=1 vectors {a,b} = 00,01,10,11 and hand-computed y1..y7
  logic [1:0] vec_ab [4]  = '{2'b00, 2'b01, 2'b10, 2'b11};
  logic [6:0] vec_y  [4]  = '{7'b0011011, 7'b0110101, 7'b0110100, 7'b1100010};

  logic [55:0] exp8;
  logic        expv8;

  initial begin
    rst = 1'b1;
    iv1 = 1'b1; a1 = '0; b1 = '0;
    iv8 = 1'b1; a8 = '0; b8 = '0;
    #1;
    chk("rst_noclk_y1", 64'(w_o1), 64'd0);
    chk("rst_noclk_v1", 64'(ov1), 64'd0);
    chk("rst_noclk_y8", 64'(w_o8), 64'd0);
    @(negedge clk);
    chk("rst_held_y1", 64'(w_o1), 64'd0);
    chk("rst_held_v1", 64'(ov1), 64'd0);
    rst = 1'b0;
    iv8 = 1'b0;

    for (int k = 0; k < 4; k++) begin
      {a1, b1} = vec_ab[k];
      @(negedge clk);
      chk($sformatf("w1_vec%0d", k), 64'(w_o1), 64'(vec_y[k]));
      chk($sformatf("w1_vld%0d", k), 64'(ov1), 64'd1);
    end

    iv1 = 1'b0; a1 = '0; b1 = '0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("hold%0d", k), 64'(w_o1), 64'(7'b1100010));
      chk($sformatf("hold_vld%0d", k), 64'(ov1), 64'd1);
    end

    chk("w8_vld_idle", 64'(ov8), 64'd0);
    iv8 = 1'b1; a8 = 8'hF0; b8 = 8'hCC;
    @(negedge clk);
    a8 = 8'hAA; b8 = 8'h55;
    chk("w8_y1", 64'(y1_8), 64'h C0);
    chk("w8_y2", 64'(y2_8), 64'h FC);
    chk("w8_y3", 64'(y3_8), 64'h 3F);
    chk("w8_y4", 64'(y4_8), 64'h 03);
    chk("w8_y5", 64'(y5_8), 64'h 3C);
    chk("w8_y6", 64'(y6_8), 64'h C3);
    chk("w8_y7", 64'(y7_8), 64'h 0F);
    chk("w8_vld", 64'(ov8), 64'd1);
    @(negedge clk);
    iv8 = 1'b0;
    chk("w8_b2b", 64'(w_o8), 64'(56'h00_FF_FF_00_FF_00_55));

    // Asynchronous reset between edges
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("amid_y1", 64'(w_o1), 64'd0);
    chk("amid_v1", 64'(ov1), 64'd0);
    chk("amid_y8", 64'(w_o8), 64'd0);
    chk("amid_v8", 64'(ov8), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    iv1 = 1'b1; a1 = 1'b1; b1 = 1'b0;
    @(negedge clk);
    iv1 = 1'b0;
    chk("post_rst_y1", 64'(w_o1), 64'(7'b0110100));
    chk("post_rst_v1", 64'(ov1), 64'd1);

    exp8  = '0;
    expv8 = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      chk("rnd_y", 64'(w_o8), 64'(exp8));
      chk("rnd_v", 64'(ov8), 64'(expv8));
      iv8 = 1'($urandom_range(0, 1));
      a8  = 8'($urandom);
      b8  = 8'($urandom);
      @(posedge clk);
      if (iv8) begin
        exp8  = ref8(a8, b8);
        expv8 = 1'b1;
      end
    end
    @(negedge clk);
    chk("rnd_last", 64'(w_o8), 64'(exp8));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
